// File: rtl/me_sad_scheduler.sv
// Sequencer for the systolic SAD array: latches the current block, streams reference
// columns on a fixed schedule and tracks the minimum SAD with its motion vector.
module me_sad_scheduler #(
    parameter int unsigned PIXELS_IN_BATCH = 16,
    parameter int unsigned EDGE_LEN        = 8,
    parameter int unsigned LOG_EDGE_LEN    = 3,
    parameter int unsigned BIT_DEPTH       = 8,
    parameter int unsigned SEARCH_W        = 16,
    parameter int unsigned SAD_LATENCY     = 17,
    parameter int unsigned ADDR_BITS       = 10,
    parameter int unsigned MVX_BITS        = 4,
    parameter int unsigned MVY_BITS        = 4
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic [ADDR_BITS-1:0]                                  ref_base_addr,
    input  logic [EDGE_LEN*EDGE_LEN*BIT_DEPTH-1:0]                cur_block_in,
    output logic [EDGE_LEN*EDGE_LEN*BIT_DEPTH-1:0]                cur_block_out,
    output logic                                                  ref_rd_en,
    output logic [ADDR_BITS-1:0]                                  ref_rd_addr,
    input  logic [PIXELS_IN_BATCH*(2*LOG_EDGE_LEN+BIT_DEPTH)-1:0] sad_in,
    output logic                                                  busy,
    output logic                                                  done,
    output logic [2*LOG_EDGE_LEN+BIT_DEPTH-1:0]                   best_sad,
    output logic [MVX_BITS-1:0]                                   best_mv_x,
    output logic [MVY_BITS-1:0]                                   best_mv_y
);

    localparam int unsigned SW       = 2 * LOG_EDGE_LEN + BIT_DEPTH;
    localparam int unsigned BLK_W    = EDGE_LEN * EDGE_LEN * BIT_DEPTH;
    localparam int unsigned NUM_COLS = SEARCH_W + EDGE_LEN - 1;
    localparam int unsigned RUN_LEN  = SAD_LATENCY + SEARCH_W;
    localparam int unsigned CNT_MAX  = ((NUM_COLS > RUN_LEN) ? NUM_COLS : RUN_LEN) + 1;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] NUM_COLS_C  = CW'(NUM_COLS);
    localparam logic [CW-1:0] RUN_LEN_C   = CW'(RUN_LEN);
    localparam logic [CW-1:0] SAD_LAT_C   = CW'(SAD_LATENCY);
    localparam logic [CW-1:0] CAND_OFFS_C = CW'(SAD_LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [BLK_W-1:0]     blk_q, blk_d;
    logic [SW-1:0]        best_sad_q, best_sad_d;
    logic [MVX_BITS-1:0]  mvx_q, mvx_d;
    logic [MVY_BITS-1:0]  mvy_q, mvy_d;

    logic [SW-1:0]        lane_min;
    logic [MVY_BITS-1:0]  lane_idx;
    logic                 capture;
    logic [CW-1:0]        cand_k;

    // Strict compare while scanning upward keeps the lowest lane on ties.
    always_comb begin
        lane_min = sad_in[SW-1:0];
        lane_idx = '0;
        for (int y = 1; y < int'(PIXELS_IN_BATCH); y++) begin
            if (sad_in[y*SW +: SW] < lane_min) begin
                lane_min = sad_in[y*SW +: SW];
                lane_idx = MVY_BITS'(y);
            end
        end
    end

    assign capture = (state_q == StRun) && (cnt_q > SAD_LAT_C);
    assign cand_k  = cnt_q - CAND_OFFS_C;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        blk_d      = blk_q;
        best_sad_d = best_sad_q;
        mvx_d      = mvx_q;
        mvy_d      = mvy_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRun;
                    cnt_d      = CW'(1);
                    addr_d     = ref_base_addr;
                    blk_d      = cur_block_in;
                    best_sad_d = '1;
                    mvx_d      = '0;
                    mvy_d      = '0;
                end
            end
            StRun: begin
                cnt_d = cnt_q + CW'(1);
                // Address stops advancing on the last feed cycle so it holds afterwards.
                if (cnt_q < NUM_COLS_C) begin
                    addr_d = addr_q + ADDR_BITS'(1);
                end
                if (capture && (lane_min < best_sad_q)) begin
                    best_sad_d = lane_min;
                    mvx_d      = MVX_BITS'(cand_k);
                    mvy_d      = lane_idx;
                end
                if (cnt_q == RUN_LEN_C) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            blk_q      <= '0;
            best_sad_q <= '0;
            mvx_q      <= '0;
            mvy_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            blk_q      <= blk_d;
            best_sad_q <= best_sad_d;
            mvx_q      <= mvx_d;
            mvy_q      <= mvy_d;
        end
    end

    assign cur_block_out = blk_q;
    assign ref_rd_en     = (state_q == StRun) && (cnt_q <= NUM_COLS_C);
    assign ref_rd_addr   = addr_q;
    assign busy          = (state_q == StRun);
    assign done          = (state_q == StDone);
    assign best_sad      = best_sad_q;
    assign best_mv_x     = mvx_q;
    assign best_mv_y     = mvy_q;

endmodule

// File: tb/tb_me_sad_scheduler.sv
// Bench for me_sad_scheduler: directed and random search runs checked cycle by cycle
// against a whole-run reference model of the schedule and the minimum search.
module tb_me_sad_scheduler;

    localparam int P   = 16;
    localparam int SW  = 14;
    localparam int SWP = 16;
    localparam int BW  = 512;
    localparam int AB  = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AB-1:0] ref_base_addr;
    logic [BW-1:0] cur_block_in;
    logic [BW-1:0] cur_block_out;
    logic          ref_rd_en;
    logic [AB-1:0] ref_rd_addr;
    logic [P*SW-1:0] sad_in;
    logic          busy;
    logic          done;
    logic [SW-1:0] best_sad;
    logic [3:0]    best_mv_x;
    logic [3:0]    best_mv_y;

    int n_cmp = 0;
    int n_err = 0;

    logic [SW-1:0] m [SWP][P];

    me_sad_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .ref_base_addr (ref_base_addr),
        .cur_block_in  (cur_block_in),
        .cur_block_out (cur_block_out),
        .ref_rd_en     (ref_rd_en),
        .ref_rd_addr   (ref_rd_addr),
        .sad_in        (sad_in),
        .busy          (busy),
        .done          (done),
        .best_sad      (best_sad),
        .best_mv_x     (best_mv_x),
        .best_mv_y     (best_mv_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_blk"}, cur_block_out, '0);
        check({tag, "_en"}, BW'(ref_rd_en), '0);
        check({tag, "_addr"}, BW'(ref_rd_addr), '0);
        check({tag, "_busy"}, BW'(busy), '0);
        check({tag, "_done"}, BW'(done), '0);
        check({tag, "_sad"}, BW'(best_sad), '0);
        check({tag, "_mvx"}, BW'(best_mv_x), '0);
        check({tag, "_mvy"}, BW'(best_mv_y), '0);
    endtask

    function automatic logic [P*SW-1:0] pack_cand(input int k);
        logic [P*SW-1:0] v;
        for (int y = 0; y < P; y++) v[y*SW +: SW] = m[k][y];
        return v;
    endfunction

    function automatic logic [P*SW-1:0] junk();
        return {7{$urandom()}};
    endfunction

    task automatic fill_const(input logic [SW-1:0] val);
        for (int k = 0; k < SWP; k++)
            for (int y = 0; y < P; y++) m[k][y] = val;
    endtask

    task automatic fill_rand(input int lo);
        for (int k = 0; k < SWP; k++)
            for (int y = 0; y < P; y++) m[k][y] = SW'($urandom_range(16383, lo));
    endtask

    // Called in an IDLE cycle, #1 after a rising edge; returns in the IDLE cycle after DONE
    // (or after recovering from a mid-run reset when abort_at is nonzero).
    task automatic run(input logic [AB-1:0] b, input int pulse_at, input int abort_at);
        logic [BW-1:0]   blk;
        logic [SW-1:0]   exp_sad;
        logic [3:0]      exp_x, exp_y;
        logic [AB-1:0]   exp_addr;
        int              last;
        blk = {16{$urandom()}};
        exp_sad = '1;
        exp_x   = '0;
        exp_y   = '0;
        for (int k = 0; k < SWP; k++)
            for (int y = 0; y < P; y++)
                if (m[k][y] < exp_sad) begin
                    exp_sad = m[k][y];
                    exp_x   = 4'(k);
                    exp_y   = 4'(y);
                end
        start = 1'b1;
        ref_base_addr = b;
        cur_block_in = blk;
        @(posedge clk); #1;
        start = 1'b0;
        cur_block_in = {16{$urandom()}};
        ref_base_addr = AB'($urandom());
        for (int c = 1; c <= 35; c++) begin
            if (c == abort_at) begin
                rst = 1'b0;
                #1;
                check_all_zero("abort");
                @(posedge clk); #1;
                rst = 1'b1;
                for (int i = 0; i < 30; i++) begin
                    check("abort_nodone", BW'(done), '0);
                    check("abort_idle", BW'(busy), '0);
                    @(posedge clk); #1;
                end
                return;
            end
            start  = (c == pulse_at);
            sad_in = (c >= 18 && c <= 33) ? pack_cand(c - 18) : junk();
            last   = (c <= 23) ? c : 23;
            exp_addr = b + AB'(last - 1);
            check($sformatf("busy_c%0d", c), BW'(busy), BW'(c <= 33));
            check($sformatf("done_c%0d", c), BW'(done), BW'(c == 34));
            check($sformatf("rden_c%0d", c), BW'(ref_rd_en), BW'(c <= 23));
            check($sformatf("addr_c%0d", c), BW'(ref_rd_addr), BW'(exp_addr));
            check($sformatf("blk_c%0d", c), cur_block_out, blk);
            if (c >= 34) begin
                check($sformatf("sad_c%0d", c), BW'(best_sad), BW'(exp_sad));
                check($sformatf("mvx_c%0d", c), BW'(best_mv_x), BW'(exp_x));
                check($sformatf("mvy_c%0d", c), BW'(best_mv_y), BW'(exp_y));
            end
            if (c < 35) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        ref_base_addr = '0;
        cur_block_in = '0;
        sad_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Timing with address wrap, random SADs
        fill_rand(0);
        run(10'h3F0, 0, 0);

        // Single clear minimum, back-to-back start
        fill_const(14'd500);
        m[5][9] = 14'd37;
        run(10'h100, 0, 0);
        check("min_sad", BW'(best_sad), BW'(37));
        check("min_mvx", BW'(best_mv_x), BW'(5));
        check("min_mvy", BW'(best_mv_y), BW'(9));

        // Ties: earliest x, then lowest lane
        fill_const(14'd500);
        m[3][12] = 14'd20;
        m[3][4]  = 14'd20;
        m[7][0]  = 14'd20;
        run(10'h055, 0, 0);
        check("tie_sad", BW'(best_sad), BW'(20));
        check("tie_mvx", BW'(best_mv_x), BW'(3));
        check("tie_mvy", BW'(best_mv_y), BW'(4));

        // Start during RUN is ignored
        fill_rand(100);
        run(10'h2A0, 12, 0);

        // Reset mid-run, then a normal run
        fill_rand(0);
        run(10'h0F0, 0, 10);
        fill_rand(0);
        run(10'h3FE, 0, 0);

        // All-ones everywhere: no improvement
        fill_const(14'h3FFF);
        run(10'h000, 0, 0);
        check("ones_sad", BW'(best_sad), BW'(14'h3FFF));
        check("ones_mvx", BW'(best_mv_x), BW'(0));
        check("ones_mvy", BW'(best_mv_y), BW'(0));

        // Zero on the very last candidate and lane
        fill_rand(1);
        m[15][15] = 14'd0;
        run(10'h1C3, 0, 0);
        check("last_sad", BW'(best_sad), BW'(0));
        check("last_mvx", BW'(best_mv_x), BW'(15));
        check("last_mvy", BW'(best_mv_y), BW'(15));

        // Idle gap, then random runs with narrow value range to provoke ties
        repeat (3) @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < SWP; k++)
                for (int y = 0; y < P; y++) m[k][y] = SW'($urandom_range(40, 10));
            run(AB'($urandom()), (r == 1) ? 30 : 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
